// File: rtl/reg_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : reg_port_arbiter
// Purpose : Register-file write / rs1 port arbiter. It passes core traffic through,
//           inserts one-cycle debug accesses, and can run a clear sweep when
//           REG_CLEAR_SWEEP_EN is defined.
// Revision: 1.0
// ============================================================================
module reg_port_arbiter #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clkIn,
    input  logic              resetIn,
    input  logic              coreWriteIn,
    input  logic [ADDR_W-1:0] coreRdIn,
    input  logic [DATA_W-1:0] coreDataIn,
    input  logic [ADDR_W-1:0] coreRs1In,
    output logic              stallOut,
    input  logic              dbgReqIn,
    input  logic              dbgWeIn,
    input  logic [ADDR_W-1:0] dbgAddrIn,
    input  logic [DATA_W-1:0] dbgDataIn,
    output logic              dbgAckOut,
    output logic [DATA_W-1:0] dbgDataOut,
    input  logic              clearReqIn,
    output logic              clearDoneOut,
    output logic              rfWriteOut,
    output logic [ADDR_W-1:0] rfRdOut,
    output logic [DATA_W-1:0] rfDataOut,
    output logic [ADDR_W-1:0] rfRs1Out,
    input  logic [DATA_W-1:0] rfData1In
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DBG   = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;
`ifdef REG_CLEAR_SWEEP_EN
    localparam logic [1:0] SWEEP = 2'd3;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);
`endif

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] dbg_data;

`ifdef REG_CLEAR_SWEEP_EN
    logic [ADDR_W-1:0] cnt;
    logic              clear_done;
    logic              sweep_last;

    assign sweep_last = (state == SWEEP) && (cnt == LAST_ADDR);

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            cnt        <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= sweep_last;
            if (sweep_last) begin
                cnt <= '0;
            end else if (state == SWEEP) begin
                cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    assign clearDoneOut = clear_done;
`else
    wire unused_cfg = &{1'b0, clearReqIn, NREGS[0]};
    assign clearDoneOut = 1'b0;
`endif

    // The clear request is checked last so that it overrides a debug request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dbgReqIn) begin
                    state_nxt = DBG;
                end
`ifdef REG_CLEAR_SWEEP_EN
                if (clearReqIn) begin
                    state_nxt = SWEEP;
                end
`endif
            end
            DBG: state_nxt = ACK;
            ACK: begin
                if (!dbgReqIn) begin
                    state_nxt = IDLE;
                end
            end
`ifdef REG_CLEAR_SWEEP_EN
            SWEEP: begin
                if (sweep_last) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // The read port shows the pre-write value in DBG, because the write lands on the same edge.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state    <= IDLE;
            dbg_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == DBG) begin
                dbg_data <= rfData1In;
            end
        end
    end

    always_comb begin
        stallOut   = 1'b0;
        rfWriteOut = coreWriteIn;
        rfRdOut    = coreRdIn;
        rfDataOut  = coreDataIn;
        rfRs1Out   = coreRs1In;
        case (state)
            DBG: begin
                stallOut   = 1'b1;
                rfWriteOut = dbgWeIn;
                rfRdOut    = dbgAddrIn;
                rfDataOut  = dbgDataIn;
                rfRs1Out   = dbgAddrIn;
            end
`ifdef REG_CLEAR_SWEEP_EN
            SWEEP: begin
                stallOut   = 1'b1;
                rfWriteOut = 1'b1;
                rfRdOut    = cnt;
                rfDataOut  = '0;
            end
`endif
            default: begin
            end
        endcase
    end

    assign dbgAckOut  = (state == ACK);
    assign dbgDataOut = dbg_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_port_arbiter
// Purpose : Directed bench for reg_port_arbiter, with a register-file model and
//           a transaction-level expectation model.
// Revision: 1.0
// ============================================================================
module tb_reg_port_arbiter;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              resetIn = 1'b1;
    logic              coreWriteIn = 1'b0;
    logic [ADDR_W-1:0] coreRdIn = '0;
    logic [DATA_W-1:0] coreDataIn = '0;
    logic [ADDR_W-1:0] coreRs1In = '0;
    logic              stallOut;
    logic              dbgReqIn = 1'b0;
    logic              dbgWeIn = 1'b0;
    logic [ADDR_W-1:0] dbgAddrIn = '0;
    logic [DATA_W-1:0] dbgDataIn = '0;
    logic              dbgAckOut;
    logic [DATA_W-1:0] dbgDataOut;
    logic              clearReqIn = 1'b0;
    logic              clearDoneOut;
    logic              rfWriteOut;
    logic [ADDR_W-1:0] rfRdOut;
    logic [DATA_W-1:0] rfDataOut;
    logic [ADDR_W-1:0] rfRs1Out;
    logic [DATA_W-1:0] rfData1In;

    reg_port_arbiter #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clkIn(clk), .resetIn(resetIn),
        .coreWriteIn(coreWriteIn), .coreRdIn(coreRdIn), .coreDataIn(coreDataIn),
        .coreRs1In(coreRs1In), .stallOut(stallOut),
        .dbgReqIn(dbgReqIn), .dbgWeIn(dbgWeIn), .dbgAddrIn(dbgAddrIn),
        .dbgDataIn(dbgDataIn), .dbgAckOut(dbgAckOut), .dbgDataOut(dbgDataOut),
        .clearReqIn(clearReqIn), .clearDoneOut(clearDoneOut),
        .rfWriteOut(rfWriteOut), .rfRdOut(rfRdOut), .rfDataOut(rfDataOut),
        .rfRs1Out(rfRs1Out), .rfData1In(rfData1In)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pat(input int i, input logic [7:0] tag);
        return {tag, 24'(i * 3 + 1)};
    endfunction

    // Register file driven by the DUT's ports
    logic [DATA_W-1:0] rf [NREGS];
    logic              preload = 1'b0;
    logic [7:0]        preload_tag = 8'h10;

    assign rfData1In = rf[rfRs1Out];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= pat(i, preload_tag);
        end else if (rfWriteOut) begin
            rf[rfRdOut] <= rfDataOut;
        end
    end

    // Expectation model: remaining sweep writes, a pending debug slot and an ack hold
    logic [DATA_W-1:0] exp_rf [NREGS];
    int                sweep_left = 0;
    int                sweep_addr = 0;
    bit                dbg_slot   = 1'b0;
    bit                ack_hold   = 1'b0;
    bit                done_pulse = 1'b0;
    bit                done_next;
    logic [DATA_W-1:0] exp_dout   = '0;
`ifdef REG_CLEAR_SWEEP_EN
    localparam bit SWEEP_ON = 1'b1;
`else
    localparam bit SWEEP_ON = 1'b0;
`endif

    always @(posedge clk or posedge resetIn) begin
        if (preload) begin
            for (int i = 0; i < NREGS; i++) exp_rf[i] = pat(i, preload_tag);
        end
        if (resetIn) begin
            sweep_left = 0;
            sweep_addr = 0;
            dbg_slot   = 1'b0;
            ack_hold   = 1'b0;
            done_pulse = 1'b0;
            exp_dout   = '0;
        end else begin
            done_next = (sweep_left == 1);
            if (dbg_slot) begin
                exp_dout = exp_rf[dbgAddrIn];
                if (dbgWeIn) exp_rf[dbgAddrIn] = dbgDataIn;
                dbg_slot = 1'b0;
                ack_hold = 1'b1;
            end else if (sweep_left > 0) begin
                exp_rf[sweep_addr] = '0;
                sweep_left--;
                sweep_addr = (sweep_left == 0) ? 0 : sweep_addr + 1;
            end else begin
                if (coreWriteIn && !preload) exp_rf[coreRdIn] = coreDataIn;
                if (ack_hold) begin
                    if (!dbgReqIn) ack_hold = 1'b0;
                end else if (SWEEP_ON && clearReqIn) begin
                    sweep_left = NREGS;
                    sweep_addr = 0;
                end else if (dbgReqIn) begin
                    dbg_slot = 1'b1;
                end
            end
            done_pulse = done_next;
        end
    end

    // Per-cycle compare against the model
    logic [31:0] e_we, e_rd, e_data, e_rs1;
    bit          cmp_rs1;

    always @(negedge clk) begin
        e_we    = {31'b0, coreWriteIn};
        e_rd    = {27'b0, coreRdIn};
        e_data  = coreDataIn;
        e_rs1   = {27'b0, coreRs1In};
        cmp_rs1 = 1'b1;
        if (dbg_slot) begin
            e_we   = {31'b0, dbgWeIn};
            e_rd   = {27'b0, dbgAddrIn};
            e_data = dbgDataIn;
            e_rs1  = {27'b0, dbgAddrIn};
        end else if (sweep_left > 0) begin
            e_we    = 32'd1;
            e_rd    = 32'(sweep_addr);
            e_data  = '0;
            cmp_rs1 = 1'b0;
        end
        chk("m_stall", {31'b0, stallOut}, {31'b0, dbg_slot || (sweep_left > 0)});
        chk("m_ack", {31'b0, dbgAckOut}, {31'b0, ack_hold});
        chk("m_done", {31'b0, clearDoneOut}, {31'b0, done_pulse});
        chk("m_dout", dbgDataOut, exp_dout);
        chk("m_we", {31'b0, rfWriteOut}, e_we);
        if (e_we[0]) begin
            chk("m_rd", {27'b0, rfRdOut}, e_rd);
            chk("m_wdata", rfDataOut, e_data);
        end
        if (cmp_rs1) chk("m_rs1", {27'b0, rfRs1Out}, e_rs1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_preload(input logic [7:0] tag);
        preload_tag = tag;
        preload     = 1'b1;
        step();
        preload     = 1'b0;
    endtask

    // Raise a debug request, measure ack latency and stall cycles, hold, then release
    task automatic dbg_access(input logic we, input logic [4:0] addr, input logic [31:0] data,
                              input int hold, output int lat, output int stalls);
        int n0;
        dbgWeIn   = we;
        dbgAddrIn = addr;
        dbgDataIn = data;
        dbgReqIn  = 1'b1;
        n0        = cyc;
        lat       = -1;
        stalls    = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (stallOut) begin
                stalls++;
                chk("dbg_we_port", {31'b0, rfWriteOut}, {31'b0, we});
                chk("dbg_rs1_port", {27'b0, rfRs1Out}, {27'b0, addr});
            end
            if (dbgAckOut) begin
                lat = cyc - n0;
                break;
            end
        end
        chk("dbg_ack_seen", {31'b0, lat > 0}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("ack_held", {31'b0, dbgAckOut}, 32'd1);
        end
        #1;
        dbgReqIn = 1'b0;
        @(negedge clk);
        chk("ack_drop", {31'b0, dbgAckOut}, 32'd0);
        #1;
    endtask

    int lat, stalls, writes, dones, done_at, n0;
    bit found;

    initial begin
        // Reset held with the register file preloaded
        pulse_preload(8'h10);
        step();
        chk("rst_stall", {31'b0, stallOut}, 32'd0);
        chk("rst_ack", {31'b0, dbgAckOut}, 32'd0);
        chk("rst_done", {31'b0, clearDoneOut}, 32'd0);
        chk("rst_dout", dbgDataOut, 32'd0);
        coreWriteIn = 1'b1; coreRdIn = 5'd20; coreDataIn = 32'h0000_0055; coreRs1In = 5'd3;
        #1;
        chk("pt_we", {31'b0, rfWriteOut}, 32'd1);
        chk("pt_rd", {27'b0, rfRdOut}, 32'd20);
        chk("pt_data", rfDataOut, 32'h55);
        chk("pt_rs1", {27'b0, rfRs1Out}, 32'd3);
        resetIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            coreWriteIn = i[0]; coreRdIn = 5'(i + 21); coreDataIn = 32'hC0DE_0000 + i; coreRs1In = 5'(i);
        end

        // Debug write of x5 while the core is trying to write x9
        coreWriteIn = 1'b1; coreRdIn = 5'd9; coreDataIn = 32'h999;
        dbg_access(1'b1, 5'd5, 32'hDEADBEEF, 0, lat, stalls);
        chk("wr_latency", 32'(lat), 32'd2);
        chk("wr_stalls", 32'(stalls), 32'd1);
        chk("rf_x5", rf[5], 32'hDEADBEEF);

        dbg_access(1'b0, 5'd5, 32'h0, 0, lat, stalls);
        chk("rd_x5", dbgDataOut, 32'hDEADBEEF);
        chk("rd_stalls", 32'(stalls), 32'd1);
        coreWriteIn = 1'b0;

        // Pre-write value returned on a debug write
        dbg_access(1'b1, 5'd7, 32'h0000_AAAA, 0, lat, stalls);
        dbg_access(1'b1, 5'd7, 32'h0000_1234, 3, lat, stalls);
        chk("prewrite_x7", dbgDataOut, 32'h0000_AAAA);
        chk("rf_x7", rf[7], 32'h0000_1234);

        // Clear sweep, request held for a single sampling edge
        clearReqIn = 1'b1;
        n0 = cyc; writes = 0; dones = 0; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stallOut && rfWriteOut && rfDataOut == '0) writes++;
            if (clearDoneOut) begin
                dones++;
                done_at = cyc - n0;
            end
            #1;
            clearReqIn = 1'b0;
        end
`ifdef REG_CLEAR_SWEEP_EN
        chk("sweep_writes", 32'(writes), 32'd32);
        chk("sweep_dones", 32'(dones), 32'd1);
        chk("sweep_done_at", 32'(done_at), 32'd33);
        chk("sweep_x5", rf[5], 32'd0);
        chk("sweep_x31", rf[31], 32'd0);
`else
        chk("sweep_writes", 32'(writes), 32'd0);
        chk("sweep_dones", 32'(dones), 32'd0);
        chk("sweep_x5", rf[5], 32'hDEADBEEF);
`endif

        // Clear and debug read raised together
        pulse_preload(8'h20);
        dbg_access(1'b1, 5'd5, 32'h5555_0005, 0, lat, stalls);
        clearReqIn = 1'b1; dbgReqIn = 1'b1; dbgWeIn = 1'b0; dbgAddrIn = 5'd5;
        n0 = cyc; lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dbgAckOut) begin
                lat = cyc - n0;
                break;
            end
            #1;
            clearReqIn = 1'b0;
        end
`ifdef REG_CLEAR_SWEEP_EN
        chk("both_ack_latency", 32'(lat), 32'd35);
        chk("both_read_x5", dbgDataOut, 32'd0);
`else
        chk("both_ack_latency", 32'(lat), 32'd2);
        chk("both_read_x5", dbgDataOut, 32'h5555_0005);
`endif
        #1;
        clearReqIn = 1'b0;
        dbgReqIn   = 1'b0;
        step();
        step();

        // Reset asserted while the sweep is at register 10
        pulse_preload(8'hA5);
        clearReqIn = 1'b1;
        step();
        clearReqIn = 1'b0;
`ifdef REG_CLEAR_SWEEP_EN
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (stallOut && rfRdOut == 5'd10) found = 1'b1;
        end
        chk("sweep_reaches_10", {31'b0, found}, 32'd1);
`else
        repeat (9) @(negedge clk);
`endif
        #1;
        resetIn = 1'b1;
        #1;
        chk("arst_stall", {31'b0, stallOut}, 32'd0);
        chk("arst_we", {31'b0, rfWriteOut}, 32'd0);
        chk("arst_done", {31'b0, clearDoneOut}, 32'd0);
        step();
        step();
        resetIn = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (clearDoneOut) dones++;
        end
        chk("arst_no_done", 32'(dones), 32'd0);
        for (int i = 0; i < NREGS; i++) begin
`ifdef REG_CLEAR_SWEEP_EN
            chk("arst_regs", rf[i], (i < 10) ? 32'd0 : pat(i, 8'hA5));
`else
            chk("arst_regs", rf[i], pat(i, 8'hA5));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_port_arbiter.md
# reg_port_arbiter

Sequencer and arbiter for the 32×32 general register file's write port and first read port. In normal operation it passes core writeback and rs1 straight through. It grants a single-word debug/host access (read and/or write) by stalling the core for one cycle. It also runs an optional 32-cycle clear sweep that zeroes every register. It sits between the core datapath (controller, IMem decode, DataMUX) and the register file.

## Interface
- `NREGS`, 32, number of registers swept; must equal 2^`ADDR_W`
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, data width
- `clkIn` in 1: the block's single clock; all state updates on its rising edge
- `resetIn` in 1: reset is asynchronous and active-high
- `coreWriteIn` in 1: core register write enable, from the controller
- `coreRdIn` in `ADDR_W`: core destination register
- `coreDataIn` in `DATA_W`: core writeback data, from DataMUX
- `coreRs1In` in `ADDR_W`: core rs1 address
- `stallOut` out 1: core must hold its PC and not commit this cycle
- `dbgReqIn` in 1: debug request, four-phase handshake
- `dbgWeIn` in 1: debug access is a write; held stable while `dbgReqIn`=1
- `dbgAddrIn` in `ADDR_W`: debug register address; held stable while `dbgReqIn`=1
- `dbgDataIn` in `DATA_W`: debug write data; held stable while `dbgReqIn`=1
- `dbgAckOut` out 1: debug access complete
- `dbgDataOut` out `DATA_W`: registered read data from the last debug access
- `clearReqIn` in 1: level request to zero all registers
- `clearDoneOut` out 1: one-cycle pulse when the sweep finishes
- `rfWriteOut` out 1: register file write enable
- `rfRdOut` out `ADDR_W`: register file write address
- `rfDataOut` out `DATA_W`: register file write data
- `rfRs1Out` out `ADDR_W`: register file rs1 address
- `rfData1In` in `DATA_W`: register file rs1 read data (combinational)

## Operation
- The FSM has four states: IDLE, DBG, ACK and SWEEP. Outputs are decoded from registered state.
- IDLE:
  - Pass-through: `rfWriteOut`=`coreWriteIn`, `rfRdOut`=`coreRdIn`, `rfDataOut`=`coreDataIn`, `rfRs1Out`=`coreRs1In`, `stallOut`=0.
  - Next state: `clearReqIn` → SWEEP (highest priority); else `dbgReqIn` → DBG; else stay in IDLE.
- DBG (exactly 1 cycle):
  - `stallOut`=1 and the core write is suppressed (dropped; the core re-executes that instruction).
  - `rfRs1Out`=`dbgAddrIn`.
  - If `dbgWeIn`: `rfWriteOut`=1, `rfRdOut`=`dbgAddrIn`, `rfDataOut`=`dbgDataIn`.
  - `dbgDataOut` captures `rfData1In` at the closing edge. This is the pre-write value, because the write lands on the same edge.
  - Next state: ACK.
- ACK:
  - `dbgAckOut`=1, `stallOut`=0, core pass-through as in IDLE.
  - Stay while `dbgReqIn`=1; go to IDLE when `dbgReqIn`=0.
- SWEEP:
  - `stallOut`=1, core write suppressed.
  - `rfWriteOut`=1, `rfRdOut`=`cnt`, `rfDataOut`=0; `cnt` increments every cycle starting from 0.
  - When `cnt`=`NREGS`-1: go to IDLE, `cnt` returns to 0, and `clearDoneOut`=1 for the first IDLE cycle (registered pulse).
- Requests arriving outside IDLE are not lost; they are evaluated on the next IDLE cycle (both are level-held).
- Reset values: state=IDLE, `cnt`=0, `dbgDataOut`=0, `dbgAckOut`=0, `clearDoneOut`=0, `stallOut`=0. Register-file-facing outputs follow IDLE pass-through.
- Reset mid-sweep or mid-debug: abort immediately. No `clearDoneOut` and no `dbgAckOut` are produced, and partially cleared registers stay as written.

## Timing
- Debug read or write latency:
  - `dbgReqIn` sampled high in IDLE at edge N.
  - DBG during cycle N→N+1; write committed at edge N+1.
  - `dbgAckOut` and valid `dbgDataOut` from N+1.
- Core stall cost per debug access: exactly 1 cycle.
- Sweep: request sampled at edge N; SWEEP occupies 32 cycles, writing registers 0..31 at edges N+1..N+32. `clearDoneOut` is high during cycle N+32→N+33.
- `clearReqIn` and `dbgReqIn` both high in IDLE: the sweep wins, and the debug access follows after it.
- `clearReqIn` still high when `clearDoneOut` pulses: a new sweep starts from IDLE.

## Configuration
- `REG_CLEAR_SWEEP_EN` defined: SWEEP state, `cnt` and `clearDoneOut` logic are compiled in, as described above.
- `REG_CLEAR_SWEEP_EN` undefined: `clearReqIn` is ignored, `clearDoneOut` is tied to 0, and no counter or SWEEP state exists. The FSM has three states.

## Test plan
- Reset held, then released with no requests → all outputs at reset values; `rfWriteOut`/`rfRdOut`/`rfDataOut`/`rfRs1Out` track core inputs with zero latency.
- Debug write x5=0xDEADBEEF → `stallOut` is high for exactly 1 cycle with `coreWriteIn` suppressed; `dbgAckOut` asserts at N+1; a following debug read of x5 returns 0xDEADBEEF.
- Debug write x7=0x1234 where x7 was 0xAAAA → `dbgDataOut`=0xAAAA (pre-write value); `dbgAckOut` stays high until `dbgReqIn` drops, then the FSM returns to IDLE.
- Clear sweep with registers preloaded nonzero → 32 consecutive writes of 0 to addresses 0..31; `clearDoneOut` pulses once at N+32; with the macro undefined, no writes occur and the pulse stays 0.
- `clearReqIn` and `dbgReqIn` raised in the same cycle → sweep completes first, then the debug access; `dbgAckOut` first rises at N+34.
- `resetIn` asserted at sweep count 10 → outputs clear asynchronously; no `clearDoneOut`; registers 10..31 are not written after reset.
